// File: rtl/sample_fifo_pkg.sv
// Sample-path constants shared by the sample FIFO and the AM modulator.
// Changing a width or level here retunes both blocks together.
package sample_fifo_pkg;

    localparam int SF_DATA_WIDTH  = 8;
    localparam int SF_ADDR_WIDTH  = 8;
    localparam int SF_AFULL_LEVEL = 192;

    typedef logic [SF_DATA_WIDTH-1:0] sf_sample_t;

endpackage

// File: rtl/sample_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// The read register has a synchronous reset so the FIFO output starts at zero.
module sample_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage itself is never reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO between the sample source and the AM modulator,
// with registered status flags and sticky overflow/underflow indicators.
module sample_fifo
    import sample_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = SF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = SF_ADDR_WIDTH,
    parameter int AFULL_LEVEL = SF_AFULL_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  write,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_flags
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(2 ** ADDR_WIDTH);
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] ONE_L   = PW'(1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [PW-1:0] w_count_nxt;

    // Handshake: write/read are one-cycle strobes; a strobe is accepted only when
    // the registered full/empty of that cycle allows it, otherwise it is dropped
    // and the matching sticky flag records the attempt.
    assign w_wr_acc = rst & write & ~r_full;
    assign w_rd_acc = rst & read & ~r_empty;

    assign w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + ONE_L : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + ONE_L : r_rd_ptr;
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    // Flags are computed from the next count so they line up with the registered count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == DEPTH_L);
            r_empty     <= (w_count_nxt == '0);
            r_afull     <= (w_count_nxt >= AFULL_L);
            r_overflow  <= (write & r_full) | (r_overflow & ~clr_flags);
            r_underflow <= (read & r_empty) | (r_underflow & ~clr_flags);
        end
    end

    sample_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (sample)
    );

    assign full        = r_full;
    assign empty       = r_empty;
    assign almost_full = r_afull;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: directed vector table, hand-written corner sequences
// and a randomized run, all compared against a queue-based reference model.
module tb_sample_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       write;
    logic       full;
    logic       almost_full;
    logic       read;
    logic [7:0] sample;
    logic       empty;
    logic [8:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_flags;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_sample;
    logic       m_ovf;
    logic       m_unf;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] data;
        logic [8:0] exp_count;
        logic [7:0] exp_sample;
        logic       exp_empty;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[8];

    sample_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .write       (write),
        .full        (full),
        .almost_full (almost_full),
        .read        (read),
        .sample      (sample),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_flags   (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cycle);
        end
    endtask

    // Model written from the FIFO rules: a queue plus sticky flags.
    task automatic model_step(input logic wr, input logic rd, input logic clr,
                              input logic rst_n, input logic [7:0] d);
        bit was_full;
        bit was_empty;
        if (!rst_n) begin
            m_q.delete();
            m_sample = 8'h00;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            was_full  = (m_q.size() == 256);
            was_empty = (m_q.size() == 0);
            if (rd && !was_empty) m_sample = m_q.pop_front();
            if (wr && !was_full) m_q.push_back(d);
            if (wr && was_full) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (rd && was_empty) m_unf = 1'b1;
            else if (clr) m_unf = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("count", 32'(count), 32'(m_q.size()));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full", 32'(full), 32'(m_q.size() == 256));
        check("almost_full", 32'(almost_full), 32'(m_q.size() >= 192));
        check("sample", 32'(sample), 32'(m_sample));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // Inputs are applied 1 time unit after a rising edge; results are checked
    // 1 time unit after the following edge.
    task automatic drive(input logic wr, input logic rd, input logic clr,
                         input logic rst_n, input logic [7:0] d);
        write     = wr;
        read      = rd;
        clr_flags = clr;
        rst       = rst_n;
        wr_data   = d;
        @(posedge clk);
        #1;
        cycle++;
        model_step(wr, rd, clr, rst_n, d);
        compare_all();
        write     = 1'b0;
        read      = 1'b0;
        clr_flags = 1'b0;
        rst       = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        bit         wr_r;
        bit         rd_r;
        int         gap;

        write = 1'b0; read = 1'b0; clr_flags = 1'b0; rst = 1'b0; wr_data = 8'h00;
        m_sample = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h10, 9'd1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h20, 9'd2, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h30, 9'd3, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 9'd2, 8'h10, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 9'd1, 8'h20, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 9'd0, 8'h30, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 9'd0, 8'h30, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 9'd0, 8'h30, 1'b1, 1'b0};

        // Reset state
        drive(0, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_sample", 32'(sample), 32'd0);

        // Directed table: basic order, underflow, flag clear
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].clr, 1'b1, vecs[i].data);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_sample", i), 32'(sample), 32'(vecs[i].exp_sample));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
        end

        // New violation wins over a same-cycle clear
        drive(0, 1, 1, 1, 8'h00);
        check("unf_priority", 32'(underflow), 32'd1);
        drive(0, 0, 1, 1, 8'h00);

        // Fill to full, almost_full threshold, overflow with 0xAA
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 256; i++) begin
            d = 8'($urandom_range(0, 8'hA9));
            drive(1, 0, 0, 1, d);
            if (i == 191) check("afull_191", 32'(almost_full), 32'd0);
            if (i == 192) check("afull_192", 32'(almost_full), 32'd1);
        end
        check("full_256", 32'(full), 32'd1);
        check("count_256", 32'(count), 32'd256);
        drive(1, 0, 0, 1, 8'hAA);
        check("overflow_aa", 32'(overflow), 32'd1);
        // Write while full with read: read accepted, write still dropped
        drive(1, 1, 0, 1, 8'hAA);
        check("count_255", 32'(count), 32'd255);
        for (int i = 0; i < 255; i++) begin
            drive(0, 1, 0, 1, 8'h00);
            check("no_aa", 32'(sample == 8'hAA), 32'd0);
        end
        check("drained_empty", 32'(empty), 32'd1);
        drive(0, 0, 1, 1, 8'h00);

        // Steady occupancy of 100 under simultaneous read+write, across pointer wrap
        for (int i = 0; i < 100; i++) drive(1, 0, 0, 1, 8'($urandom));
        for (int i = 0; i < 300; i++) drive(1, 1, 0, 1, 8'($urandom));
        check("steady_100", 32'(count), 32'd100);

        // Mid-operation reset at count 50
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 50; i++) drive(1, 0, 0, 1, 8'($urandom));
        drive(0, 0, 0, 0, 8'h00);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_sample", 32'(sample), 32'd0);
        drive(1, 0, 0, 1, 8'h5A);
        drive(0, 1, 0, 1, 8'h00);
        check("after_rst_5a", 32'(sample), 32'h5A);

        // Consumer draining a 0..255 ramp at irregular intervals
        drive(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 256; i++) drive(1, 0, 0, 1, 8'(i));
        for (int i = 0; i < 256; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) drive(0, 0, 0, 1, 8'h00);
            drive(0, 1, 0, 1, 8'h00);
            check("ramp_sample", 32'(sample), 32'(i));
        end
        check("ramp_no_unf", 32'(underflow), 32'd0);

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 600; i++) begin
                wr_r = ($urandom_range(0, 99) < ((p % 2 == 0) ? 80 : 30));
                rd_r = ($urandom_range(0, 99) < ((p % 2 == 0) ? 30 : 80));
                drive(wr_r, rd_r, ($urandom_range(0, 31) == 0),
                      ($urandom_range(0, 499) != 0), 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
